// File: rtl/apb_dmem_ctrl.sv
// APB3 data-memory port sequencer: IDLE -> SETUP -> ACCESS -> DONE.
// Define APB_DMEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
module apb_dmem_ctrl #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  state_e            state_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              err_q;
  logic              req;

`ifdef APB_DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
`endif

  assign req = req_read | req_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
`ifdef APB_DMEM_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            // write wins when both requests are raised
            pwrite_q <= req_write;
            paddr_q  <= req_addr;
            pwdata_q <= req_wdata;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
`ifdef APB_DMEM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            err_q     <= pslverr;
            if (!pwrite_q && !pslverr) begin
              rdata_q  <= prdata;
              rvalid_q <= 1'b1;
            end
            state_q <= DONE;
          end
`ifdef APB_DMEM_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= DONE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall = ((state_q == IDLE) && req)
               || (state_q == SETUP)
               || (state_q == ACCESS);

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign err         = err_q;

endmodule
